counter_seq_ctrl: RTL and testbench

//   Run-control sequencer for a modulo-N counter datapath: start/stop/pause, load, clear.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/mod_n_counter.sv | 44 ++++
 rtl/counter_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared types and constants for the counter run-control slice.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ============================================================================
//  Module   : mod_n_counter
//  Purpose  : Modulo-N counter datapath with clear, load and increment.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mod_n_counter #(
    parameter  int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] C_MAX = W'(N - 1);

    logic [W-1:0] r_count;

    // Terminal compare is against N-1 only, so non-power-of-2 N never reaches N.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (ld) begin
            r_count <= ld_val;
        end else if (inc) begin
            r_count <= at_max ? '0 : r_count + W'(1);
        end
    end

    assign at_max = (r_count == C_MAX);
    assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
// ============================================================================
//  Module   : counter_seq_ctrl
//  Purpose  : Run-control sequencer (start/stop/load/clear) for a mod-N counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter  int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         mode,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         wrap,
    output logic         done,
    output logic [1:0]   state_o
);

    localparam logic [W:0] C_N_EXT = (W+1)'(N);

    ctrl_state_t  r_state;
    ctrl_state_t  w_next_state;
    logic         r_mode;
    logic         r_busy;
    logic         r_wrap;
    logic         r_done;
    logic         w_inc;
    logic         w_ld;
    logic         w_clr;
    logic         w_wrap;
    logic         w_done;
    logic         w_mode_ld;
    logic         w_at_max;
    logic [W-1:0] w_ld_val;

    assign w_ld_val = ({1'b0, load_val} >= C_N_EXT) ? W'(N - 1) : load_val;

    mod_n_counter #(.N(N)) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_inc),
        .ld      (w_ld),
        .ld_val  (w_ld_val),
        .clr     (w_clr),
        .count   (count),
        .at_max  (w_at_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: clear > stop > load_en > start > tick; load/start have no effect in RUN.
    always_comb begin
        w_next_state = r_state;
        w_inc        = 1'b0;
        w_ld         = 1'b0;
        w_clr        = 1'b0;
        w_wrap       = 1'b0;
        w_done       = 1'b0;
        w_mode_ld    = 1'b0;
        if (clear) begin
            w_next_state = IDLE;
            w_clr        = 1'b1;
        end else if (stop) begin
            if (r_state == RUN) begin
                w_next_state = PAUSE;
            end
        end else if (r_state == RUN) begin
            if (tick) begin
                w_inc = 1'b1;
                if (w_at_max) begin
                    w_wrap = 1'b1;
                    if (r_mode == MODE_ONESHOT) begin
                        w_next_state = DONE;
                        w_done       = 1'b1;
                    end
                end
            end
        end else if (load_en) begin
            w_ld = 1'b1;
        end else if (start) begin
            w_next_state = RUN;
            w_mode_ld    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= MODE_ONESHOT;
            r_busy <= 1'b0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_mode_ld) begin
                r_mode <= (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
            end
            r_busy <= (w_next_state == RUN);
            r_wrap <= w_wrap;
            r_done <= w_done;
        end
    end

    assign busy    = r_busy;
    assign wrap    = r_wrap;
    assign done    = r_done;
    assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
// ============================================================================
//  Module   : tb_counter_seq_ctrl
//  Purpose  : Self-checking bench; N=8 and N=6 instances share one stimulus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stop, clear, load_en, mode, tick;
    logic [2:0] load_val;

    logic [2:0] cnt8, cnt6;
    logic       busy8, wrap8, done8, busy6, wrap6, done6;
    logic [1:0] st8, st6;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 -> N=8, index 1 -> N=6
    int NV[2] = '{8, 6};
    int m_st[2], m_cnt[2], m_mode[2], m_wrap[2], m_done[2];

    typedef struct {
        logic       start, stop, clear, load_en;
        logic [2:0] load_val;
        logic       mode, tick;
        int         e_cnt, e_st;
        logic       e_busy, e_wrap, e_done;
    } vec_t;
    vec_t tbl[30];

    always #5 clk = ~clk;

    counter_seq_ctrl #(.N(8)) u8 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .load_en(load_en), .load_val(load_val), .mode(mode), .tick(tick),
        .count(cnt8), .busy(busy8), .wrap(wrap8), .done(done8), .state_o(st8)
    );

    counter_seq_ctrl #(.N(6)) u6 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .load_en(load_en), .load_val(load_val), .mode(mode), .tick(tick),
        .count(cnt6), .busy(busy6), .wrap(wrap6), .done(done6), .state_o(st6)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_mode[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
        end
    endtask

    // States: 0 idle, 1 run, 2 pause, 3 done
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 0;
            m_done[i] = 0;
            if (clear) begin
                m_st[i] = 0; m_cnt[i] = 0;
            end else if (stop) begin
                if (m_st[i] == 1) m_st[i] = 2;
            end else if (m_st[i] == 1) begin
                if (tick) begin
                    if (m_cnt[i] == NV[i] - 1) begin
                        m_cnt[i]  = 0;
                        m_wrap[i] = 1;
                        if (m_mode[i] == 0) begin
                            m_st[i] = 3; m_done[i] = 1;
                        end
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end else if (load_en) begin
                m_cnt[i] = (int'(load_val) >= NV[i]) ? NV[i] - 1 : int'(load_val);
            end else if (start) begin
                m_st[i] = 1; m_mode[i] = int'(mode);
            end
        end
    endtask

    task automatic cmp_model();
        chk("u8.count", int'(cnt8), m_cnt[0]);
        chk("u8.state", int'(st8),  m_st[0]);
        chk("u8.busy",  int'(busy8), (m_st[0] == 1) ? 1 : 0);
        chk("u8.wrap",  int'(wrap8), m_wrap[0]);
        chk("u8.done",  int'(done8), m_done[0]);
        chk("u6.count", int'(cnt6), m_cnt[1]);
        chk("u6.state", int'(st6),  m_st[1]);
        chk("u6.busy",  int'(busy6), (m_st[1] == 1) ? 1 : 0);
        chk("u6.wrap",  int'(wrap6), m_wrap[1]);
        chk("u6.done",  int'(done6), m_done[1]);
    endtask

    task automatic set_in(input logic s, input logic sp, input logic cl, input logic ld,
                          input logic [2:0] lv, input logic md, input logic tk);
        start = s; stop = sp; clear = cl; load_en = ld; load_val = lv; mode = md; tick = tk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        cmp_model();
    endtask

    task automatic exp8(input string name, input int c, input int s, input int b,
                        input int w, input int d);
        chk({name, ".count"}, int'(cnt8), c);
        chk({name, ".state"}, int'(st8), s);
        chk({name, ".busy"},  int'(busy8), b);
        chk({name, ".wrap"},  int'(wrap8), w);
        chk({name, ".done"},  int'(done8), d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 3'd0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp8("reset", 0, 0, 0, 0, 0);
        cmp_model();
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table: one-shot pass then 20 ticks in auto-reload
        tbl[0] = '{1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 0, 0};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{0, 0, 0, 0, 3'd0, 0, 1, k % 8, (k == 8) ? 3 : 1,
                       (k != 8), (k == 8), (k == 8)};
        tbl[9] = '{1, 0, 0, 0, 3'd0, 1, 0, 0, 1, 1, 0, 0};
        for (int j = 1; j <= 20; j++)
            tbl[9 + j] = '{0, 0, 0, 0, 3'd0, 0, 1, j % 8, 1, 1, (j % 8 == 0), 0};

        @(posedge clk); #1;
        for (int k = 0; k < 30; k++) begin
            set_in(tbl[k].start, tbl[k].stop, tbl[k].clear, tbl[k].load_en,
                   tbl[k].load_val, tbl[k].mode, tbl[k].tick);
            step();
            exp8($sformatf("vec%0d", k), tbl[k].e_cnt, tbl[k].e_st,
                 int'(tbl[k].e_busy), int'(tbl[k].e_wrap), int'(tbl[k].e_done));
        end

        // stop beats coincident tick; pause ignores ticks; resume continues
        set_in(0, 0, 1, 0, 3'd0, 0, 0); step();
        set_in(1, 0, 0, 0, 3'd0, 1, 0); step();
        set_in(0, 0, 0, 0, 3'd0, 0, 1); repeat (3) step();
        exp8("run3", 3, 1, 1, 0, 0);
        set_in(0, 1, 0, 0, 3'd0, 0, 1); step();
        exp8("stop_tick", 3, 2, 0, 0, 0);
        set_in(0, 0, 0, 0, 3'd0, 0, 1); repeat (3) step();
        exp8("pause_ticks", 3, 2, 0, 0, 0);
        set_in(1, 0, 0, 0, 3'd0, 1, 0); step();
        set_in(0, 0, 0, 0, 3'd0, 0, 1); step();
        exp8("resume", 4, 1, 1, 0, 0);

        // load, clamp on N=6, then terminal tick in one-shot
        set_in(0, 0, 1, 0, 3'd0, 0, 0); step();
        set_in(0, 0, 0, 1, 3'd5, 0, 0); step();
        exp8("load5", 5, 0, 0, 0, 0);
        set_in(0, 0, 0, 1, 3'd7, 0, 0); step();
        chk("clamp.u6.count", int'(cnt6), 5);
        set_in(1, 0, 0, 1, 3'd2, 0, 0); step();
        chk("load_start.u8.count", int'(cnt8), 2);
        chk("load_start.u8.state", int'(st8), 0);
        set_in(0, 0, 0, 1, 3'd7, 0, 0); step();
        set_in(1, 0, 0, 0, 3'd0, 0, 0); step();
        set_in(0, 0, 0, 0, 3'd0, 0, 1); step();
        chk("clamp_tick.u6.wrap", int'(wrap6), 1);
        chk("clamp_tick.u6.count", int'(cnt6), 0);
        chk("clamp_tick.u6.state", int'(st6), 3);

        // clear with coincident terminal tick
        set_in(0, 0, 1, 0, 3'd0, 0, 0); step();
        set_in(0, 0, 0, 1, 3'd7, 0, 0); step();
        set_in(1, 0, 0, 0, 3'd0, 0, 0); step();
        exp8("at_max", 7, 1, 1, 0, 0);
        set_in(0, 0, 1, 0, 3'd0, 0, 1); step();
        exp8("clear_tick", 0, 0, 0, 0, 0);

        // asynchronous reset mid-RUN
        set_in(1, 0, 0, 0, 3'd0, 1, 0); step();
        set_in(0, 0, 0, 0, 3'd0, 0, 1); repeat (2) step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        exp8("async_rst", 0, 0, 0, 0, 0);
        cmp_model();
        @(posedge clk); #1;
        cmp_model();
        #3;
        reset_n = 1'b1;
        repeat (3) step();
        exp8("post_rst_ticks", 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 3'd0, 0, 0); step();
        set_in(0, 0, 0, 0, 3'd0, 0, 1); step();
        exp8("post_rst_run", 1, 1, 1, 0, 0);

        // randomized traffic against the reference model
        for (int r = 0; r < 2000; r++) begin
            set_in(($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 5),
                   ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 60));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
